// File: rtl/alu_arbiter.sv
// Purpose : shares one combinational ALU between two requesters, round-robin grant.
// Latency : accept edge 0 -> alu_* after edge 0, rsp_data/rspN_valid after edge 1, release at earliest on edge 2.
// Backpressure: new requests are refused until the owner consumes its response; the result is held while stalled.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   reqN_valid_i/reqN_ready_o       operation handshake from requester N (code, a, b)
//   rspN_valid_o/rspN_ready_i       result handshake to requester N, data on shared rsp_data_o
//   alu_code_o/alu_a_o/alu_b_o      registered operands to the shared ALU
//   alu_c_i                         ALU result, combinational from alu_*
//   busy_o                          high while an operation is in flight
module alu_arbiter #(
    parameter int DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [1:0]        req0_code_i,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [1:0]        req1_code_i,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,

    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [DATA_W:0]   rsp_data_o,

    output logic [1:0]        alu_code_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W:0]   alu_c_i,

    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]        code;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } op_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            prio_q, prio_d;
    op_t             op_q, op_d;
    logic [DATA_W:0] rsp_data_q, rsp_data_d;
    logic [1:0]      rsp_vld_q, rsp_vld_d;

    op_t  req0_op, req1_op, gnt_op;
    logic gnt_sel;      // 1 selects requester 1
    logic gnt_vld;
    logic own_rsp_rdy;

    assign req0_op = '{code: req0_code_i, a: req0_a_i, b: req0_b_i};
    assign req1_op = '{code: req1_code_i, a: req1_a_i, b: req1_b_i};

    // Requester 1 wins when it is alone or when both ask and it holds priority.
    assign gnt_sel = req1_valid_i && (!req0_valid_i || prio_q);
    assign gnt_vld = req0_valid_i || req1_valid_i;
    assign gnt_op  = gnt_sel ? req1_op : req0_op;

    // Only the owner's ready can release the response; the other one is ignored.
    assign own_rsp_rdy = owner_q ? rsp1_ready_i : rsp0_ready_i;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        prio_d       = prio_q;
        op_d         = op_q;
        rsp_data_d   = rsp_data_q;
        rsp_vld_d    = rsp_vld_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Ready is suppressed during reset so no request looks accepted.
                if (gnt_vld && !rst_i) begin
                    req0_ready_o = !gnt_sel;
                    req1_ready_o = gnt_sel;
                    owner_d      = gnt_sel;
                    op_d         = gnt_op;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d = alu_c_i;
                rsp_vld_d  = owner_q ? 2'b10 : 2'b01;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (own_rsp_rdy) begin
                    rsp_vld_d = 2'b00;
                    prio_d    = ~owner_q;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            prio_q     <= 1'b0;
            op_q       <= '0;
            rsp_data_q <= '0;
            rsp_vld_q  <= 2'b00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
            rsp_vld_q  <= rsp_vld_d;
        end
    end

    assign alu_code_o   = op_q.code;
    assign alu_a_o      = op_q.a;
    assign alu_b_o      = op_q.b;
    assign rsp_data_o   = rsp_data_q;
    assign rsp0_valid_o = rsp_vld_q[0];
    assign rsp1_valid_o = rsp_vld_q[1];
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose : self-checking bench for alu_arbiter with a transaction-level reference model.
// Latency : n/a (bench).
// Backpressure: drives random response stalls and held requests.
module tb_alu_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req_v;
    logic [1:0] req_r;
    logic [1:0] req_code [2];
    logic [3:0] req_a [2];
    logic [3:0] req_b [2];
    logic [1:0] rsp_v;
    logic [1:0] rsp_r;
    logic [4:0] rsp_data;
    logic [1:0] alu_code;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [4:0] alu_c;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Shared ALU: 0 add, 1 subtract, 2 and, 3 or; 5-bit result.
    function automatic logic [4:0] alu_f(logic [1:0] c, logic [3:0] a, logic [3:0] b);
        case (c)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    assign alu_c = alu_f(alu_code, alu_a, alu_b);

    alu_arbiter #(.DATA_W(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (req_v[0]),
        .req0_ready_o (req_r[0]),
        .req0_code_i  (req_code[0]),
        .req0_a_i     (req_a[0]),
        .req0_b_i     (req_b[0]),
        .req1_valid_i (req_v[1]),
        .req1_ready_o (req_r[1]),
        .req1_code_i  (req_code[1]),
        .req1_a_i     (req_a[1]),
        .req1_b_i     (req_b[1]),
        .rsp0_valid_o (rsp_v[0]),
        .rsp0_ready_i (rsp_r[0]),
        .rsp1_valid_o (rsp_v[1]),
        .rsp1_ready_i (rsp_r[1]),
        .rsp_data_o   (rsp_data),
        .alu_code_o   (alu_code),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_c_i      (alu_c),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one transaction in flight, tracked by its age in cycles.
    bit         m_busy;
    int         m_age;      // 0: operands registered, 1: result presented
    bit         m_owner;
    bit         m_prio;
    logic [1:0] m_code;
    logic [3:0] m_a, m_b;
    logic [4:0] m_data;
    bit   [1:0] m_acc;      // requester accepted on the last edge

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_grant();
        if (req_v[0] && req_v[1]) return m_prio ? 1 : 0;
        if (req_v[1])             return 1;
        if (req_v[0])             return 0;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_age   = 0;
        m_owner = 0;
        m_prio  = 0;
        m_code  = '0;
        m_a     = '0;
        m_b     = '0;
        m_data  = '0;
        m_acc   = '0;
    endtask

    task automatic check_outputs();
        int g;
        g = m_grant();
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("req%0d_ready", n), 32'(req_r[n]),
                32'(!rst && !m_busy && g == n));
            chk($sformatf("rsp%0d_valid", n), 32'(rsp_v[n]),
                32'(m_busy && m_age == 1 && int'(m_owner) == n));
        end
        chk("busy", 32'(busy), 32'(m_busy));
        chk("rsp_data", 32'(rsp_data), 32'(m_data));
        chk("alu_code", 32'(alu_code), 32'(m_code));
        chk("alu_a", 32'(alu_a), 32'(m_a));
        chk("alu_b", 32'(alu_b), 32'(m_b));
    endtask

    task automatic model_advance();
        int g;
        m_acc = '0;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            g = m_grant();
            if (g >= 0) begin
                m_busy   = 1;
                m_age    = 0;
                m_owner  = (g == 1);
                m_code   = req_code[g];
                m_a      = req_a[g];
                m_b      = req_b[g];
                m_acc[g] = 1'b1;
            end
        end else if (m_age == 0) begin
            m_age  = 1;
            m_data = alu_f(m_code, m_a, m_b);
        end else if (rsp_r[m_owner]) begin
            m_busy = 0;
            m_prio = !m_owner;
        end
    endtask

    // Check mid-cycle, then step across one rising edge.
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic set_req(int n, logic [1:0] c, logic [3:0] a, logic [3:0] b);
        req_code[n] = c;
        req_a[n]    = a;
        req_b[n]    = b;
    endtask

    typedef struct {
        int         who;
        logic [1:0] code;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[6];
    int   order[$];
    int   cnt;

    initial begin
        vecs[0] = '{0, 2'd0, 4'd7,  4'd13, 5'b10100};
        vecs[1] = '{1, 2'd1, 4'd5,  4'd3,  5'd2};
        vecs[2] = '{0, 2'd1, 4'd3,  4'd5,  5'd30};
        vecs[3] = '{1, 2'd2, 4'd12, 4'd10, 5'd8};
        vecs[4] = '{0, 2'd3, 4'd12, 4'd3,  5'd15};
        vecs[5] = '{1, 2'd0, 4'd15, 4'd15, 5'd30};

        model_reset();
        rst   = 1'b1;
        req_v = '0;
        rsp_r = '0;
        set_req(0, 2'd0, 4'd0, 4'd0);
        set_req(1, 2'd0, 4'd0, 4'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_v), 32'd0);

        // Table-driven single operations, one requester at a time.
        foreach (vecs[i]) begin
            set_req(vecs[i].who, vecs[i].code, vecs[i].a, vecs[i].b);
            req_v[vecs[i].who] = 1'b1;
            #1;
            chk("vec_accept_ready", 32'(req_r[vecs[i].who]), 32'd1);
            tick();
            req_v = '0;
            chk("vec_alu_a", 32'(alu_a), 32'(vecs[i].a));
            chk("vec_alu_b", 32'(alu_b), 32'(vecs[i].b));
            tick();
            chk("vec_rsp_valid", 32'(rsp_v), 32'(2'b01 << vecs[i].who));
            chk("vec_rsp_data", 32'(rsp_data), 32'(vecs[i].exp));
            rsp_r[vecs[i].who] = 1'b1;
            tick();
            rsp_r = '0;
            chk("vec_busy_after", 32'(busy), 32'd0);
        end

        // Response stall on requester 1 for five cycles.
        set_req(1, 2'd0, 4'd9, 4'd9);
        req_v[1] = 1'b1;
        tick();
        req_v = '0;
        tick();
        repeat (5) tick();
        chk("stall_rsp_valid", 32'(rsp_v), 32'b10);
        chk("stall_rsp_data", 32'(rsp_data), 32'd18);
        rsp_r[1] = 1'b1;
        tick();
        rsp_r = '0;
        chk("stall_release_valid", 32'(rsp_v), 32'd0);
        chk("stall_release_busy", 32'(busy), 32'd0);

        // Contention from reset: grants must alternate, one op per 3 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 2'd0, 4'd1, 4'd2);
        set_req(1, 2'd3, 4'd5, 4'd10);
        req_v = 2'b11;
        rsp_r = 2'b11;
        order.delete();
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_r[0]) order.push_back(0);
            if (req_r[1]) order.push_back(1);
            tick();
        end
        req_v = '0;
        rsp_r = '0;
        chk("contention_count", 32'(order.size()), 32'd4);
        foreach (order[k]) chk($sformatf("contention_order%0d", k), 32'(order[k]), 32'(k % 2));

        // Requester 1 arrives while requester 0 executes.
        set_req(0, 2'd0, 4'd2, 4'd3);
        req_v[0] = 1'b1;
        tick();
        req_v[0] = 1'b0;
        set_req(1, 2'd1, 4'd8, 4'd1);
        req_v[1] = 1'b1;
        #1;
        chk("wait_ready_exec", 32'(req_r[1]), 32'd0);
        tick();
        rsp_r = 2'b11;
        #1;
        chk("wait_ready_resp", 32'(req_r[1]), 32'd0);
        tick();
        #1;
        chk("wait_ready_idle", 32'(req_r[1]), 32'd1);
        tick();
        req_v = '0;
        tick();
        chk("wait_rsp_data", 32'(rsp_data), 32'd7);
        chk("wait_rsp_valid", 32'(rsp_v), 32'b10);
        tick();
        rsp_r = '0;

        // Reset while a response is pending.
        set_req(0, 2'd2, 4'd3, 4'd6);
        req_v[0] = 1'b1;
        tick();
        req_v = '0;
        tick();
        chk("rstmid_rsp_valid_before", 32'(rsp_v), 32'b01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_rsp_valid", 32'(rsp_v), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_alu_a", 32'(alu_a), 32'd0);
        chk("rstmid_rsp_data", 32'(rsp_data), 32'd0);
        rst   = 1'b1;
        req_v = 2'b11;
        #1;
        chk("ready_in_reset", 32'(req_r), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid_first_grant", 32'(req_r), 32'b01);
        tick();
        req_v = '0;
        rsp_r = 2'b11;
        tick();
        tick();
        rsp_r = '0;

        // Lone requester 1 issuing back-to-back.
        set_req(1, 2'd0, 4'd6, 4'd4);
        req_v[1] = 1'b1;
        rsp_r[1] = 1'b1;
        cnt = 0;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (req_r[1]) cnt++;
            if (req_r[0]) chk("lone_req0_ready", 32'(req_r[0]), 32'd0);
            tick();
        end
        req_v = '0;
        rsp_r = '0;
        chk("lone_accepts", 32'(cnt), 32'd3);

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!req_v[n] || m_acc[n]) begin
                    req_v[n] = ($urandom_range(0, 2) != 0);
                    set_req(n, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                            4'($urandom_range(0, 15)));
                end
            end
            rsp_r = 2'($urandom_range(0, 3));
            rst   = ($urandom_range(0, 50) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one instance of the team's combinational 4-bit ALU (2-bit op code, two operands, 5-bit result) between two requesters. Each requester issues an operation over a valid/ready handshake. The arbiter grants one requester at a time by round-robin, drives the ALU operand and code inputs from registers, and captures the ALU result one cycle later. It then returns the result to the owning requester over a second valid/ready handshake. It sits between the ALU instance and two client blocks, for example a microsequencer and a test/debug port.

## Interface
- `DATA_W`, default 4: operand width. The ALU result is `DATA_W+1` bits.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` / `req1_valid` in 1: requester N has an operation pending.
- `req0_ready` / `req1_ready` out 1: operation from requester N is accepted this cycle.
- `req0_code` / `req1_code` in 2: ALU op code.
- `req0_a` / `req1_a` in DATA_W: operand a.
- `req0_b` / `req1_b` in DATA_W: operand b.
- `rsp0_valid` / `rsp1_valid` out 1: result for requester N is available.
- `rsp0_ready` / `rsp1_ready` in 1: requester N consumes the result.
- `rsp_data` out DATA_W+1: captured ALU result. Shared by both requesters; qualified by `rspN_valid`.
- `alu_code` out 2: registered op code driven to the ALU.
- `alu_a` out DATA_W: registered operand a driven to the ALU.
- `alu_b` out DATA_W: registered operand b driven to the ALU.
- `alu_c` in DATA_W+1: ALU result, combinational from `alu_*`.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Internal registers:
  - `owner` (1 bit)
  - `prio` (1 bit): the preferred requester.
- **IDLE**:
  - Grant is combinational: if only one `reqN_valid` is high, grant N. If both are high, grant `prio`.
  - `reqN_ready` = (state==IDLE) && grant==N && `reqN_valid`. At most one ready is high in any cycle.
  - On an accept edge: `alu_code`/`alu_a`/`alu_b` <= granted request fields, `owner` <= N, go to EXEC.
- **EXEC**: `rsp_data` <= `alu_c`, `rsp<owner>_valid` <= 1, go to RESP. This is unconditional.
- **RESP**:
  - Hold `rsp<owner>_valid`, `rsp_data` and `alu_*` stable.
  - On the edge where `rsp<owner>_ready` is high: valid <= 0, `prio` <= ~`owner`, go to IDLE.
  - `rspN_ready` from the non-owner is ignored.
- Requests arriving in EXEC/RESP wait. `reqN_ready` stays low and the requester must hold its fields stable while valid is high.
- The arbiter performs no arithmetic; the result width is `DATA_W+1` exactly as produced by the ALU, with no truncation or extension.
- `rsp_data` and `alu_*` keep their last values in IDLE. They are not cleared.

## Timing
- Reset values:
  - state IDLE
  - `prio` 0, `owner` 0
  - `alu_code`, `alu_a`, `alu_b` 0
  - `rsp_data` 0
  - `rsp0_valid`, `rsp1_valid` 0
  - `busy` 0
  - Both `reqN_ready` are 0 during reset.
- Latency: if the accept edge is cycle 0, `alu_*` is valid after edge 0, `rsp_data`/`rspN_valid` are valid after edge 1, and the earliest release is edge 2.
- Maximum throughput is one operation per 3 cycles when `rspN_ready` is held high.
- Back-to-back: the IDLE cycle after RESP can accept a new request. That request uses the updated `prio`.
- Simultaneous requests:
  - First grant after reset goes to req0.
  - If both requesters hold valid continuously, grants strictly alternate 0,1,0,1.
- A single requester may be granted repeatedly; `prio` flipping does not block it when the other is idle.
- Reset mid-operation (EXEC or RESP):
  - The next edge returns everything to reset values.
  - The in-flight result is discarded and no `rspN_valid` is produced for it.
  - The requester must reissue.
- `rspN_ready` asserted while `rspN_valid` is low has no effect.

## Test plan
- Single op: req0 with code=0 (add), a=4'b0111, b=4'b1101 -> `req0_ready` high in the same cycle, `alu_a`=7 and `alu_b`=13 one cycle later, `rsp0_valid`=1 with `rsp_data`=5'b10100 two cycles after accept, `rsp1_valid` stays 0.
- Response stall: hold `rsp1_ready`=0 for 5 cycles after `rsp1_valid` rises -> `rsp1_valid`, `rsp_data` and `alu_*` stable throughout; after `rsp1_ready`=1, valid drops on that edge and `busy` falls.
- Contention: both requesters valid continuously with `rspN_ready`=1 for 4 ops -> grant order req0, req1, req0, req1; each op takes 3 cycles (12 total); each response matches the ALU output for that requester's operands.
- Waiting requester: req1 rises while req0's op is in EXEC -> `req1_ready` stays low until IDLE, then req1 is accepted with its held fields.
- Reset mid-op: assert `rst` in RESP with `rsp0_valid`=1 -> after the edge, all outputs are at reset values and the next simultaneous request is granted to req0.
- Lone requester: only req1 issues 3 ops -> all 3 are granted to req1 with no idle bubbles beyond the IDLE cycle.
